// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB and issue buses of the ALU issue queue.
// The master side is the surrounding pipeline; the slave side is the queue.
interface alu_issue_queue_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int CTRL_W = 16
);
  logic              disp_valid;
  logic              disp_ready;
  logic [CTRL_W-1:0] disp_ctrl;
  logic [TAG_W-1:0]  disp_dest_tag;
  logic              disp_a_rdy;
  logic [TAG_W-1:0]  disp_a_tag;
  logic [DATA_W-1:0] disp_a_val;
  logic              disp_b_rdy;
  logic [TAG_W-1:0]  disp_b_tag;
  logic [DATA_W-1:0] disp_b_val;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              iss_valid;
  logic              iss_ready;
  logic [CTRL_W-1:0] iss_ctrl;
  logic [DATA_W-1:0] iss_src_a;
  logic [DATA_W-1:0] iss_src_b;
  logic [TAG_W-1:0]  iss_dest_tag;

  modport master (
    output disp_valid, disp_ctrl, disp_dest_tag,
           disp_a_rdy, disp_a_tag, disp_a_val,
           disp_b_rdy, disp_b_tag, disp_b_val,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  disp_ready, iss_valid, iss_ctrl, iss_src_a, iss_src_b, iss_dest_tag
  );

  modport slave (
    input  disp_valid, disp_ctrl, disp_dest_tag,
           disp_a_rdy, disp_a_tag, disp_a_val,
           disp_b_rdy, disp_b_tag, disp_b_val,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output disp_ready, iss_valid, iss_ctrl, iss_src_a, iss_src_b, iss_dest_tag
  );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU reservation station: collapsing queue (index 0 oldest), CDB wakeup with
// dispatch bypass, oldest-ready select into a registered issue stage.
module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int CTRL_W = 16,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_queue_if.slave bus,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  dest;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
  } ent_t;

  ent_t              q     [DEPTH];
  ent_t              w     [DEPTH+1];  // woken view; w[DEPTH] is the empty slot shifted in
  ent_t              q_nxt [DEPTH];
  ent_t              d_ent;
  logic [DEPTH-1:0]  rdy;
  logic              any_rdy;
  logic [IDX_W-1:0]  sel;
  logic              load_en, do_iss, do_disp;
  logic [CNT_W-1:0]  tail;

  logic              iss_valid_q;
  logic [CTRL_W-1:0] iss_ctrl_q;
  logic [DATA_W-1:0] iss_a_q, iss_b_q;
  logic [TAG_W-1:0]  iss_dest_q;

  assign bus.disp_ready   = (count < CNT_W'(DEPTH));
  assign bus.iss_valid    = iss_valid_q;
  assign bus.iss_ctrl     = iss_ctrl_q;
  assign bus.iss_src_a    = iss_a_q;
  assign bus.iss_src_b    = iss_b_q;
  assign bus.iss_dest_tag = iss_dest_q;

  assign load_en = !iss_valid_q | bus.iss_ready;
  assign do_iss  = load_en & any_rdy;
  assign do_disp = bus.disp_valid & bus.disp_ready;
  assign tail    = count - CNT_W'(do_iss);

  // Readiness from registered state only, and CDB wakeup of every entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = q[i].vld & q[i].a_rdy & q[i].b_rdy;
      w[i]   = q[i];
      if (bus.cdb_valid && q[i].vld && !q[i].a_rdy && q[i].a_tag == bus.cdb_tag) begin
        w[i].a_rdy = 1'b1;
        w[i].a_val = bus.cdb_value;
      end
      if (bus.cdb_valid && q[i].vld && !q[i].b_rdy && q[i].b_tag == bus.cdb_tag) begin
        w[i].b_rdy = 1'b1;
        w[i].b_val = bus.cdb_value;
      end
    end
    w[DEPTH] = '0;
  end

  // Oldest (lowest-index) ready entry
  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel     = IDX_W'(i);
        any_rdy = 1'b1;
      end
    end
  end

  // Incoming op with same-cycle CDB bypass so a broadcast is never missed
  always_comb begin
    d_ent       = '0;
    d_ent.vld   = 1'b1;
    d_ent.ctrl  = bus.disp_ctrl;
    d_ent.dest  = bus.disp_dest_tag;
    d_ent.a_rdy = bus.disp_a_rdy;
    d_ent.a_tag = bus.disp_a_tag;
    d_ent.a_val = bus.disp_a_val;
    d_ent.b_rdy = bus.disp_b_rdy;
    d_ent.b_tag = bus.disp_b_tag;
    d_ent.b_val = bus.disp_b_val;
    if (bus.cdb_valid && !bus.disp_a_rdy && bus.disp_a_tag == bus.cdb_tag) begin
      d_ent.a_rdy = 1'b1;
      d_ent.a_val = bus.cdb_value;
    end
    if (bus.cdb_valid && !bus.disp_b_rdy && bus.disp_b_tag == bus.cdb_tag) begin
      d_ent.b_rdy = 1'b1;
      d_ent.b_val = bus.cdb_value;
    end
  end

  // Collapse above the issued slot, then write dispatch at the adjusted tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_iss && IDX_W'(i) >= sel) q_nxt[i] = w[i+1];
      else                            q_nxt[i] = w[i];
      if (do_disp && CNT_W'(i) == tail) q_nxt[i] = d_ent;
    end
  end

  // Queue storage and occupancy; reset and flush wipe everything
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count <= count + CNT_W'(do_disp) - CNT_W'(do_iss);
    end
  end

  // Issue register: loads when empty or consumed, otherwise holds
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      iss_valid_q <= 1'b0;
      iss_ctrl_q  <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_dest_q  <= '0;
    end else if (load_en) begin
      iss_valid_q <= any_rdy;
      if (any_rdy) begin
        iss_ctrl_q <= q[sel].ctrl;
        iss_a_q    <= q[sel].a_val;
        iss_b_q    <= q[sel].b_val;
        iss_dest_q <= q[sel].dest;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus randomized phases, all
// checked every cycle against a queue-based reference model.
module tb_alu_issue_queue;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] count;

  alu_issue_queue_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CTRL_W(CTRL_W)) bus();

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  dest;
    logic              a_rdy;
    logic [TAG_W-1:0]  a_tag;
    logic [DATA_W-1:0] a_val;
    logic              b_rdy;
    logic [TAG_W-1:0]  b_tag;
    logic [DATA_W-1:0] b_val;
  } op_t;

  op_t mq[$];
  op_t m_iss;
  bit  m_iv;
  int  n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the queue is a list in age order; issue removes the first ready op
  task automatic model_step();
    bit  load_en;
    int  idx;
    bit  dok;
    op_t n;
    load_en = !m_iv || bus.iss_ready;
    idx = -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].a_rdy && mq[i].b_rdy) begin idx = i; break; end
    dok = bus.disp_valid && (mq.size() < DEPTH);
    if (flush) begin
      mq.delete();
      m_iv = 0;
      return;
    end
    if (load_en) begin
      if (idx >= 0) begin m_iss = mq[idx]; mq.delete(idx); m_iv = 1; end
      else m_iv = 0;
    end
    if (bus.cdb_valid)
      foreach (mq[i]) begin
        if (!mq[i].a_rdy && mq[i].a_tag == bus.cdb_tag) begin mq[i].a_rdy = 1; mq[i].a_val = bus.cdb_value; end
        if (!mq[i].b_rdy && mq[i].b_tag == bus.cdb_tag) begin mq[i].b_rdy = 1; mq[i].b_val = bus.cdb_value; end
      end
    if (dok) begin
      n = '{bus.disp_ctrl, bus.disp_dest_tag, bus.disp_a_rdy, bus.disp_a_tag, bus.disp_a_val,
            bus.disp_b_rdy, bus.disp_b_tag, bus.disp_b_val};
      if (bus.cdb_valid && !n.a_rdy && n.a_tag == bus.cdb_tag) begin n.a_rdy = 1; n.a_val = bus.cdb_value; end
      if (bus.cdb_valid && !n.b_rdy && n.b_tag == bus.cdb_tag) begin n.b_rdy = 1; n.b_val = bus.cdb_value; end
      mq.push_back(n);
    end
  endtask

  task automatic compare();
    chk("count", 64'(count), 64'(mq.size()));
    chk("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < DEPTH));
    chk("iss_valid", 64'(bus.iss_valid), 64'(m_iv));
    if (m_iv) begin
      chk("iss_ctrl", 64'(bus.iss_ctrl), 64'(m_iss.ctrl));
      chk("iss_src_a", bus.iss_src_a, m_iss.a_val);
      chk("iss_src_b", bus.iss_src_b, m_iss.b_val);
      chk("iss_dest_tag", 64'(bus.iss_dest_tag), 64'(m_iss.dest));
    end
  endtask

  // Inputs are set at the falling edge; one call advances one clock
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in();
    bus.disp_valid = 0; bus.disp_ctrl = '0; bus.disp_dest_tag = '0;
    bus.disp_a_rdy = 0; bus.disp_a_tag = '0; bus.disp_a_val = '0;
    bus.disp_b_rdy = 0; bus.disp_b_tag = '0; bus.disp_b_val = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_value = '0;
    flush = 0;
  endtask

  task automatic disp(input logic [CTRL_W-1:0] c, input logic [TAG_W-1:0] d,
                      input logic ar, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] av,
                      input logic br, input logic [TAG_W-1:0] bt, input logic [DATA_W-1:0] bv);
    bus.disp_valid = 1; bus.disp_ctrl = c; bus.disp_dest_tag = d;
    bus.disp_a_rdy = ar; bus.disp_a_tag = at; bus.disp_a_val = av;
    bus.disp_b_rdy = br; bus.disp_b_tag = bt; bus.disp_b_val = bv;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_value = v;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    m_iv = 0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_iss_ctrl", 64'(bus.iss_ctrl), 64'd0);
    chk("rst_iss_src_a", bus.iss_src_a, 64'd0);
    chk("rst_iss_src_b", bus.iss_src_b, 64'd0);
    chk("rst_iss_dest", 64'(bus.iss_dest_tag), 64'd0);
    rst_n = 1;
  endtask

  task automatic rand_phase(input int cycles, input int p_disp, input int p_ird,
                            input int p_rdy, input int p_cdb, input int p_flush);
    for (int k = 0; k < cycles; k++) begin
      idle_in();
      bus.iss_ready = ($urandom_range(99) < p_ird);
      if ($urandom_range(99) < p_disp)
        disp(CTRL_W'($urandom), TAG_W'($urandom),
             $urandom_range(99) < p_rdy, TAG_W'($urandom), {$urandom, $urandom},
             $urandom_range(99) < p_rdy, TAG_W'($urandom), {$urandom, $urandom});
      if ($urandom_range(99) < p_cdb) cdb(TAG_W'($urandom), {$urandom, $urandom});
      flush = ($urandom_range(999) < p_flush);
      cyc();
    end
  endtask

  initial begin
    idle_in();
    bus.iss_ready = 1;
    @(negedge clk);
    do_reset();

    // ADD with both operands ready
    disp(16'h0001, 4'd3, 1, 4'd0, 64'd5, 1, 4'd0, 64'd7);
    cyc();
    idle_in();
    repeat (3) cyc();

    // X waits on tag 6, younger Y is ready and overtakes it
    disp(16'h00AA, 4'd1, 1, 4'd0, 64'd9, 0, 4'd6, 64'd0);
    cyc();
    disp(16'h00BB, 4'd2, 1, 4'd0, 64'd1, 1, 4'd0, 64'd2);
    cyc();
    idle_in();
    cdb(4'd6, 64'h40);
    cyc();
    idle_in();
    repeat (4) cyc();

    // Same-cycle dispatch and broadcast on both operands
    disp(16'h00CC, 4'd4, 0, 4'd2, 64'd0, 0, 4'd2, 64'd0);
    cdb(4'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc();
    idle_in();
    repeat (3) cyc();

    // Fill with waiting ops, refuse while full, wake, hold, drain
    for (int i = 0; i < DEPTH; i++) begin
      disp(CTRL_W'(16'h100 + i), TAG_W'(i), 0, TAG_W'(8 + (i % 4)), '0, 1, '0, 64'(i));
      cyc();
    end
    disp(16'h0DEF, 4'd15, 1, '0, 64'd77, 1, '0, 64'd88);
    cyc();
    idle_in();
    bus.iss_ready = 0;
    for (int t = 8; t < 12; t++) begin cdb(TAG_W'(t), 64'(t * 16)); cyc(); end
    idle_in();
    repeat (3) cyc();
    bus.iss_ready = 1;
    cyc();
    disp(16'h0DEF, 4'd15, 1, '0, 64'd77, 1, '0, 64'd88);
    cyc();
    idle_in();
    repeat (DEPTH + 3) cyc();

    // Flush with queued ops and a held issue, while dispatching
    bus.iss_ready = 0;
    for (int i = 0; i < 6; i++) begin
      disp(CTRL_W'(16'h200 + i), TAG_W'(i), 1, '0, 64'(i), 1, '0, 64'(i + 1));
      cyc();
    end
    idle_in();
    cyc();
    disp(16'h0EEE, 4'd9, 1, '0, 64'd1, 1, '0, 64'd1);
    flush = 1;
    cyc();
    idle_in();
    bus.iss_ready = 1;
    repeat (4) cyc();

    // Randomized phases: balanced, fill-heavy, drain-heavy, flushy
    rand_phase(600, 60, 70, 50, 40, 0);
    rand_phase(400, 90, 15, 30, 30, 0);
    rand_phase(400, 20, 90, 40, 60, 0);
    idle_in();
    bus.iss_ready = 0;
    cyc();
    do_reset();
    rand_phase(600, 70, 60, 50, 50, 15);
    rand_phase(400, 100, 100, 100, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
